clock_period_meter: RTL and testbench

//  Measures a slow, possibly asynchronous square wave, e.g. a divided clock, against the

---
 rtl/clock_period_meter.sv | 147 ++++++++++++++
 tb/tb_clock_period_meter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_period_meter.sv
// clock_period_meter: measures period and high time of a slow, possibly
// asynchronous square wave in system-clock cycles. Emits a one-cycle valid
// strobe per completed period and a one-cycle timeout strobe when no rising
// edge arrives for MAX_COUNT cycles.
module clock_period_meter #(
  parameter int WIDTH     = 27,
  parameter int MAX_COUNT = 100000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             enable,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             timeout,
  output logic             locked
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  state_t           state, state_nxt;
  logic             sync_q, sig_s, sig_d;
  logic             rise, at_max;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] hi, hi_nxt;
  logic [WIDTH-1:0] period_nxt, high_nxt;
  logic             valid_nxt, timeout_nxt, locked_nxt;

  // Two-flop synchronizer plus one delay stage for edge detection; runs
  // independently of enable so the edge detector is primed on re-enable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= 1'b0;
      sig_s  <= 1'b0;
      sig_d  <= 1'b0;
    end else begin
      sync_q <= sig_in;
      sig_s  <= sync_q;
      sig_d  <= sig_s;
    end
  end

  assign rise   = sig_s & ~sig_d;
  assign at_max = (cnt == MAX_C);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ARM;
    else       state <= state_nxt;
  end

  // Next-state logic: enable low forces IDLE from anywhere.
  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = ARM;
        ARM:     if (rise) state_nxt = MEASURE;
        MEASURE: if (!rise && at_max) state_nxt = ARM;
        default: state_nxt = ARM;
      endcase
    end
  end

  // Output/datapath next values. A rise always beats the timeout bound, so
  // a period of exactly MAX_COUNT cycles still measures cleanly.
  always_comb begin
    cnt_nxt     = cnt;
    hi_nxt      = hi;
    period_nxt  = period;
    high_nxt    = high_time;
    valid_nxt   = 1'b0;
    timeout_nxt = 1'b0;
    locked_nxt  = locked;
    if (!enable) begin
      cnt_nxt    = '0;
      hi_nxt     = '0;
      locked_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nxt    = '0;
          hi_nxt     = '0;
          locked_nxt = 1'b0;
        end
        ARM: begin
          if (rise) begin
            cnt_nxt = ONE;
            hi_nxt  = ONE;
          end else if (at_max) begin
            timeout_nxt = 1'b1;
            cnt_nxt     = '0;
          end else begin
            cnt_nxt = cnt + ONE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_nxt = cnt;
            high_nxt   = hi;
            valid_nxt  = 1'b1;
            locked_nxt = 1'b1;
            cnt_nxt    = ONE;
            hi_nxt     = ONE;
          end else if (at_max) begin
            timeout_nxt = 1'b1;
            locked_nxt  = 1'b0;
            cnt_nxt     = '0;
            hi_nxt      = '0;
          end else begin
            cnt_nxt = cnt + ONE;
            hi_nxt  = hi + {{(WIDTH-1){1'b0}}, sig_s};
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      hi        <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
      locked    <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      hi        <= hi_nxt;
      period    <= period_nxt;
      high_time <= high_nxt;
      valid     <= valid_nxt;
      timeout   <= timeout_nxt;
      locked    <= locked_nxt;
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// Bench for clock_period_meter (WIDTH=8, MAX_COUNT=16). A cycle-level
// reference model expresses results as index distances and sample sums over
// a history of synchronized samples; table rows and hand sequences add
// fixed expectations for the divider, timeout, enable and reset cases.
module tb_clock_period_meter;
  localparam int W   = 8;
  localparam int MAX = 16;

  logic         clock = 1'b0;
  logic         reset, sig_in, enable;
  logic [W-1:0] period, high_time;
  logic         valid, timeout, locked;

  clock_period_meter #(.WIDTH(W), .MAX_COUNT(MAX)) dut (
    .clock(clock), .reset(reset), .sig_in(sig_in), .enable(enable),
    .period(period), .high_time(high_time), .valid(valid),
    .timeout(timeout), .locked(locked)
  );

  always #5 clock = ~clock;

  int checks = 0, failures = 0;
  int dut_valids = 0, dut_timeouts = 0;

  // Reference model: cycle index n, anchor = cycle where the running count
  // was zero, last_rise = cycle of the previous counted rise (-1 = none).
  int  n = 0, anchor = 0, last_rise = -1;
  bit  m_en;
  bit  f1, s, d;
  bit  hist[int];
  int  m_period, m_high;
  bit  m_valid, m_timeout, m_locked;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    f1 = 0; s = 0; d = 0;
    m_en = 1; anchor = n; last_rise = -1;
    m_period = 0; m_high = 0;
    m_valid = 0; m_timeout = 0; m_locked = 0;
  endtask

  task automatic model_edge(input bit sin, input bit en);
    bit rise;
    int sum;
    rise = s & ~d;
    hist[n] = s;
    m_valid = 0;
    m_timeout = 0;
    if (!en) begin
      m_en = 0; m_locked = 0; last_rise = -1;
    end else if (!m_en) begin
      m_en = 1; anchor = n + 1; last_rise = -1;
    end else if (rise) begin
      if (last_rise >= 0) begin
        sum = 0;
        for (int i = last_rise; i < n; i++) sum += int'(hist[i]);
        m_period = n - last_rise;
        m_high   = sum;
        m_valid  = 1;
        m_locked = 1;
      end
      last_rise = n;
      anchor = n;
    end else if (n - anchor == MAX) begin
      m_timeout = 1; m_locked = 0; last_rise = -1; anchor = n + 1;
    end
    d = s; s = f1; f1 = sin;
    n++;
  endtask

  // One clock: drive at negedge, model at posedge, compare 1 time unit later.
  task automatic step(input bit sin, input bit en);
    sig_in = sin;
    enable = en;
    @(posedge clock);
    model_edge(sin, en);
    #1;
    check("valid", int'(valid), int'(m_valid));
    check("timeout", int'(timeout), int'(m_timeout));
    check("locked", int'(locked), int'(m_locked));
    check("period", int'(period), m_period);
    check("high_time", int'(high_time), m_high);
    if (valid) dut_valids++;
    if (timeout) dut_timeouts++;
    @(negedge clock);
  endtask

  task automatic run_wave(input int plen, input int hlen, input int reps, input bit en);
    for (int r = 0; r < reps; r++)
      for (int p = 0; p < plen; p++)
        step(p < hlen, en);
  endtask

  // Reset asserted for one full clock; outputs must clear without an edge.
  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    check("rst_period", int'(period), 0);
    check("rst_high_time", int'(high_time), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_timeout", int'(timeout), 0);
    check("rst_locked", int'(locked), 0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  typedef struct {
    int plen;
    int hlen;
    int reps;
    int exp_period;
    int exp_high;
    int exp_locked;
  } vec_t;

  initial begin
    vec_t tbl[4];
    int   v0, t0;
    int   tq[$];
    int   plen, hlen, reps;
    bit   en;

    tbl[0] = '{5, 2, 6, 5, 2, 1};
    tbl[1] = '{4, 2, 6, 4, 2, 1};
    tbl[2] = '{5, 2, 6, 5, 2, 1};
    tbl[3] = '{16, 8, 4, 16, 8, 1};

    sig_in = 0; enable = 0; reset = 0;
    #1 reset = 1;
    model_reset();
    @(negedge clock);
    check("init_period", int'(period), 0);
    check("init_high_time", int'(high_time), 0);
    check("init_valid", int'(valid), 0);
    check("init_timeout", int'(timeout), 0);
    check("init_locked", int'(locked), 0);
    reset = 0;

    // Divider rows, run back to back: 5/2, 4/2, back to 5/2, then period 16
    // where the rise lands exactly on the timeout bound.
    for (int k = 0; k < 4; k++) begin
      v0 = dut_valids; t0 = dut_timeouts;
      run_wave(tbl[k].plen, tbl[k].hlen, tbl[k].reps, 1'b1);
      check("tbl_period", int'(period), tbl[k].exp_period);
      check("tbl_high_time", int'(high_time), tbl[k].exp_high);
      check("tbl_locked", int'(locked), tbl[k].exp_locked);
      check("tbl_no_timeout", dut_timeouts - t0, 0);
      check("tbl_valid_seen", int'((dut_valids - v0) >= tbl[k].reps - 2), 1);
    end

    // Input held low after lock: periodic timeout every MAX+1 cycles, results held.
    v0 = dut_valids;
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 1'b1);
      if (timeout) tq.push_back(i);
    end
    check("stall_timeouts", int'(tq.size() >= 3), 1);
    if (tq.size() >= 2) check("stall_interval", tq[1] - tq[0], MAX + 1);
    check("stall_no_valid", dut_valids - v0, 0);
    check("stall_locked", int'(locked), 0);
    check("stall_period_held", int'(period), 16);
    check("stall_high_held", int'(high_time), 8);

    // Enable dropped mid-period for 10 cycles.
    run_wave(5, 2, 4, 1'b1);
    step(1'b1, 1'b1);
    v0 = dut_valids; t0 = dut_timeouts;
    run_wave(5, 2, 2, 1'b0);
    check("idle_no_valid", dut_valids - v0, 0);
    check("idle_no_timeout", dut_timeouts - t0, 0);
    check("idle_locked", int'(locked), 0);
    check("idle_period_held", int'(period), 5);
    check("idle_high_held", int'(high_time), 2);
    run_wave(5, 2, 4, 1'b1);
    check("reen_period", int'(period), 5);
    check("reen_locked", int'(locked), 1);

    // Reset mid-period, then measurement resumes.
    step(1'b1, 1'b1);
    step(1'b1, 1'b0 | 1'b1);
    pulse_reset();
    run_wave(5, 2, 4, 1'b1);
    check("post_rst_period", int'(period), 5);
    check("post_rst_high", int'(high_time), 2);
    check("post_rst_locked", int'(locked), 1);

    // Randomized segments: mixed periods (some beyond the bound), enable
    // drops, raw noise and occasional resets, all against the model.
    for (int seg = 0; seg < 250; seg++) begin
      plen = $urandom_range(2, 20);
      hlen = $urandom_range(1, plen - 1);
      reps = $urandom_range(1, 5);
      en   = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 9))
        0: for (int i = 0; i < 12; i++) step(1'($urandom_range(0, 1)), en);
        1: pulse_reset();
        2: for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
        default: run_wave(plen, hlen, reps, en);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
